// File: rtl/ysyx_23060201_stu_if.sv
// Store-unit bus bundle: EXU store request channel, memory write channel, status.
// Latency: n/a (wires only).
// Backpressure: st_ready toward the requester, mem_wready from memory.
// Ports (signals): st_valid/st_ready/st_addr/st_data/st_size, mem_wen/mem_wready/
//   mem_waddr/mem_wdata/mem_wmask, st_err, busy.
// slave  = the store buffer itself; master = the environment (EXU + memory).
interface ysyx_23060201_stu_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_wen;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        st_err;
    logic        busy;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_wready,
        output st_ready, mem_wen, mem_waddr, mem_wdata, mem_wmask, st_err, busy
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_wready,
        input  st_ready, mem_wen, mem_waddr, mem_wdata, mem_wmask, st_err, busy
    );
endinterface

// File: rtl/ysyx_23060201_stu.sv
// Store buffer: queues EXU stores and issues byte-lane-aligned memory writes in order.
// Latency: one cycle from accept to earliest mem_wen (no bypass).
// Backpressure: st_ready = !full, independent of mem_wready; head held while !mem_wready.
// Ports: clk, rst_n (async active-low), bus (ysyx_23060201_stu_if.slave).
// Optional feature: define STU_MISALIGN_CHK_EN to reject misaligned half/word stores.
// Stores below MBASE are rejected with a one-cycle st_err pulse.
`ifndef MBASE
`define MBASE 32'h8000_0000
`endif

module ysyx_23060201_stu #(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ysyx_23060201_stu_if.slave    bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } entry_t;

    entry_t          buf_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            full;
    logic            empty;
    logic            accept;
    logic            reject;
    logic            push;
    logic            pop;
    entry_t          head;
    logic [1:0]      off;

    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign accept = bus.st_valid && !full;

    always_comb begin
        reject = (bus.st_addr < `MBASE);
`ifdef STU_MISALIGN_CHK_EN
        if (bus.st_size == 2'd1 && bus.st_addr[0])
            reject = 1'b1;
        if (bus.st_size == 2'd2 && bus.st_addr[1:0] != 2'b00)
            reject = 1'b1;
`endif
    end

    assign push = accept && !reject;
    assign pop  = !empty && bus.mem_wready;

    // Next-state: pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        err_d  = accept && reject;
        if (push)
            wptr_d = wptr_q + PW'(1);
        if (pop)
            rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Payload storage needs no reset: only slots covered by cnt_q are ever observed.
    always_ff @(posedge clk) begin
        if (push)
            buf_q[wptr_q] <= '{addr: bus.st_addr, data: bus.st_data, size: bus.st_size};
    end

    assign head = buf_q[rptr_q];
    assign off  = head.addr[1:0];

    // Lane placement; bits shifted past lane 3 fall off the 4-bit mask / 32-bit data.
    always_comb begin
        bus.mem_wmask = 4'b1111;
        bus.mem_wdata = head.data;
        case (head.size)
            2'd0: begin
                bus.mem_wmask = 4'b0001 << off;
                bus.mem_wdata = head.data << {off, 3'b000};
            end
            2'd1: begin
                bus.mem_wmask = 4'b0011 << off;
                bus.mem_wdata = head.data << {off, 3'b000};
            end
            default: begin
                bus.mem_wmask = 4'b1111;
                bus.mem_wdata = head.data;
            end
        endcase
    end

    assign bus.mem_waddr = {head.addr[31:2], 2'b00};
    assign bus.mem_wen   = !empty;
    assign bus.st_ready  = !full;
    assign bus.st_err    = err_q;
    assign bus.busy      = !empty;

endmodule

// File: tb/tb_ysyx_23060201_stu.sv
// Directed bench for the store buffer: inputs change 1 time unit after a rising
// edge, outputs are checked at that same point (settled post-edge state).
`ifndef MBASE
`define MBASE 32'h8000_0000
`endif

module tb_ysyx_23060201_stu;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    localparam logic [31:0] MB = `MBASE;

    ysyx_23060201_stu_if bus ();

    ysyx_23060201_stu #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s);
        bus.st_valid = v;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_size  = s;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 2'd0);
        bus.mem_wready = 1'b1;
        #12;
        chk("rst_st_ready", {31'b0, bus.st_ready}, 32'd1);
        chk("rst_mem_wen",  {31'b0, bus.mem_wen},  32'd0);
        chk("rst_busy",     {31'b0, bus.busy},     32'd0);
        chk("rst_st_err",   {31'b0, bus.st_err},   32'd0);
        rst_n = 1'b1;
        tick();

        // Byte store into lane 3
        drive(1'b1, MB + 32'd3, 32'h0000_00AB, 2'd0);
        tick();
        drive(1'b0, '0, '0, 2'd0);
        chk("b_wen",   {31'b0, bus.mem_wen}, 32'd1);
        chk("b_waddr", bus.mem_waddr, MB);
        chk("b_wmask", {28'b0, bus.mem_wmask}, 32'h8);
        chk("b_wdata", bus.mem_wdata, 32'hAB00_0000);
        chk("b_busy",  {31'b0, bus.busy}, 32'd1);
        tick();
        chk("b_wen_after",  {31'b0, bus.mem_wen}, 32'd0);
        chk("b_busy_after", {31'b0, bus.busy}, 32'd0);

        // Half store into upper lanes
        drive(1'b1, MB + 32'd2, 32'h0000_1234, 2'd1);
        tick();
        drive(1'b0, '0, '0, 2'd0);
        chk("h_wmask", {28'b0, bus.mem_wmask}, 32'hC);
        chk("h_wdata", bus.mem_wdata, 32'h1234_0000);
        chk("h_waddr", bus.mem_waddr, MB);
        tick();
        chk("h_busy_after", {31'b0, bus.busy}, 32'd0);

        // Three word stores with memory stalled: fill, stall, drain in order
        bus.mem_wready = 1'b0;
        drive(1'b1, MB + 32'h8, 32'h1111_1111, 2'd2);
        tick();
        chk("w_rdy_1", {31'b0, bus.st_ready}, 32'd1);
        drive(1'b1, MB + 32'hC, 32'h2222_2222, 2'd2);
        tick();
        chk("w_rdy_2", {31'b0, bus.st_ready}, 32'd0);
        drive(1'b1, MB + 32'h10, 32'h3333_3333, 2'd2);
        tick();
        chk("w_rdy_stall",   {31'b0, bus.st_ready}, 32'd0);
        chk("w_stall_wdata", bus.mem_wdata, 32'h1111_1111);
        chk("w_stall_waddr", bus.mem_waddr, MB + 32'h8);
        chk("w_stall_wmask", {28'b0, bus.mem_wmask}, 32'hF);
        tick();
        chk("w_stall2_wdata", bus.mem_wdata, 32'h1111_1111);
        bus.mem_wready = 1'b1;
        tick();
        chk("w_d1_wdata", bus.mem_wdata, 32'h2222_2222);
        chk("w_d1_waddr", bus.mem_waddr, MB + 32'hC);
        chk("w_d1_rdy",   {31'b0, bus.st_ready}, 32'd1);
        tick();
        drive(1'b0, '0, '0, 2'd0);
        chk("w_d2_wdata", bus.mem_wdata, 32'h3333_3333);
        chk("w_d2_waddr", bus.mem_waddr, MB + 32'h10);
        chk("w_d2_busy",  {31'b0, bus.busy}, 32'd1);
        tick();
        chk("w_drained", {31'b0, bus.mem_wen}, 32'd0);

        // Store below MBASE is rejected
        drive(1'b1, MB - 32'd4, 32'hCAFE_F00D, 2'd2);
        tick();
        drive(1'b0, '0, '0, 2'd0);
        chk("lo_err",  {31'b0, bus.st_err}, 32'd1);
        chk("lo_wen",  {31'b0, bus.mem_wen}, 32'd0);
        tick();
        chk("lo_err_off", {31'b0, bus.st_err}, 32'd0);
        chk("lo_wen2",    {31'b0, bus.mem_wen}, 32'd0);

        // Misaligned word store
        bus.mem_wready = 1'b0;
        drive(1'b1, MB + 32'd1, 32'hDEAD_BEEF, 2'd2);
        tick();
        drive(1'b0, '0, '0, 2'd0);
`ifdef STU_MISALIGN_CHK_EN
        chk("mis_err", {31'b0, bus.st_err}, 32'd1);
        chk("mis_wen", {31'b0, bus.mem_wen}, 32'd0);
`else
        chk("mis_err",   {31'b0, bus.st_err}, 32'd0);
        chk("mis_wen",   {31'b0, bus.mem_wen}, 32'd1);
        chk("mis_wmask", {28'b0, bus.mem_wmask}, 32'hF);
        chk("mis_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("mis_waddr", bus.mem_waddr, MB);
`endif

        // Aligned store left pending, then asynchronous reset mid-transfer
        drive(1'b1, MB + 32'h20, 32'h5555_AAAA, 2'd2);
        tick();
        drive(1'b0, '0, '0, 2'd0);
        chk("pre_rst_wen", {31'b0, bus.mem_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_wen",   {31'b0, bus.mem_wen},  32'd0);
        chk("arst_busy",  {31'b0, bus.busy},     32'd0);
        chk("arst_ready", {31'b0, bus.st_ready}, 32'd1);
        chk("arst_err",   {31'b0, bus.st_err},   32'd0);
        #1;
        rst_n = 1'b1;
        bus.mem_wready = 1'b1;
        chk("rel_wen", {31'b0, bus.mem_wen}, 32'd0);

        // First edge after release accepts a request
        drive(1'b1, MB + 32'h40, 32'h0000_0005, 2'd2);
        tick();
        drive(1'b0, '0, '0, 2'd0);
        chk("post_wen",   {31'b0, bus.mem_wen}, 32'd1);
        chk("post_waddr", bus.mem_waddr, MB + 32'h40);
        chk("post_wdata", bus.mem_wdata, 32'h0000_0005);
        tick();
        chk("post_busy", {31'b0, bus.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
